// File: rtl/li_multi_input_buffer_pkg.sv
// ============================================================================
//  Package    : li_shell_pkg
//  Description: Shared constants and helpers for the latency-insensitive shell.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package li_shell_pkg;

  localparam int LI_DEFAULT_WIDTH    = 6;
  localparam int LI_DEFAULT_ADDR     = 2;
  localparam int LI_MAX_CHANNELS     = 32;

  // One bit per channel: set when that channel can supply a token this cycle.
  typedef logic [LI_MAX_CHANNELS-1:0] li_ready_mask_t;

  // Occupancy at which a channel starts asking upstream to stop.
  function automatic int li_af_level(input int depth, input int margin);
    return depth - margin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/li_multi_input_buffer_if.sv
// ============================================================================
//  Interface  : li_multi_input_buffer_if
//  Description: Upstream enqueue, back-pressure and pearl-side dequeue signals.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface li_multi_input_buffer_if #(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 2
);
  logic [CHANNELS*WIDTH-1:0] i_data;
  logic [CHANNELS-1:0]       i_enq;
  logic [CHANNELS-1:0]       o_stop;
  logic [CHANNELS-1:0]       o_full;
  logic [CHANNELS-1:0]       o_empty;
  logic [CHANNELS-1:0]       o_error;
  logic [CHANNELS*WIDTH-1:0] o_data;
  logic                      o_valid;
  logic                      i_deq;

  modport slave (
    input  i_data, i_enq, i_deq,
    output o_stop, o_full, o_empty, o_error, o_data, o_valid
  );

  modport master (
    output i_data, i_enq, i_deq,
    input  o_stop, o_full, o_empty, o_error, o_data, o_valid
  );
endinterface

`default_nettype wire

// File: rtl/li_multi_input_buffer_channel_fifo.sv
// ============================================================================
//  Module     : li_channel_fifo
//  Description: One first-word-fall-through channel FIFO with stop/error flags.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module li_channel_fifo
  import li_shell_pkg::*;
#(
  parameter int WIDTH     = LI_DEFAULT_WIDTH,
  parameter int ADDR      = LI_DEFAULT_ADDR,
  parameter int AF_MARGIN = 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_enq,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_stop,
  output logic                  o_error
);

  localparam int            DEPTH    = 2 ** ADDR;
  localparam logic [ADDR:0] c_DEPTH  = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] c_AF_LVL = (ADDR+1)'(li_af_level(DEPTH, AF_MARGIN));

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR-1:0]  r_wr_ptr;
  logic [ADDR-1:0]  r_rd_ptr;
  logic [ADDR:0]    r_count;
  logic             r_error;
  logic             w_do_rd;
  logic             w_do_wr;

  assign o_full  = (r_count == c_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_stop  = (r_count >= c_AF_LVL);
  assign o_error = r_error;
  assign o_head  = r_mem[r_rd_ptr];

  // A pop while empty only happens on the bypass path: the token goes
  // straight to the pearl, so nothing is stored and nothing is read.
  assign w_do_rd = i_pop && !o_empty;
  assign w_do_wr = i_enq && (!o_full || i_pop) && !(i_pop && o_empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + ADDR'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR'(1);
      end
      r_count <= r_count + {{ADDR{1'b0}}, w_do_wr} - {{ADDR{1'b0}}, w_do_rd};
      if (i_enq && o_full && !i_pop) begin
        r_error <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/li_multi_input_buffer.sv
// ============================================================================
//  Module     : li_multi_input_buffer
//  Description: Per-channel FIFOs joined into one aligned token set for the pearl.
//               Optional zero-latency path: define LI_INPUT_BUFFER_BYPASS_EN.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module li_multi_input_buffer
  import li_shell_pkg::*;
#(
  parameter int WIDTH     = LI_DEFAULT_WIDTH,
  parameter int ADDR      = LI_DEFAULT_ADDR,
  parameter int CHANNELS  = 2,
  parameter int AF_MARGIN = 1
) (
  input  wire logic               clk,
  input  wire logic               reset,
  li_multi_input_buffer_if.slave  bus
);

  logic [CHANNELS-1:0]       w_empty;
  logic [CHANNELS-1:0]       w_ready;
  logic [CHANNELS*WIDTH-1:0] w_head;
  logic [CHANNELS*WIDTH-1:0] w_data;
  logic                      w_valid;
  logic                      w_pop;

  assign w_valid     = &w_ready;
  assign w_pop       = bus.i_deq && w_valid;
  assign bus.o_valid = w_valid;
  assign bus.o_empty = w_empty;
  assign bus.o_data  = w_data;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    li_channel_fifo #(
      .WIDTH     (WIDTH),
      .ADDR      (ADDR),
      .AF_MARGIN (AF_MARGIN)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_data  (bus.i_data[c*WIDTH +: WIDTH]),
      .i_enq   (bus.i_enq[c]),
      .i_pop   (w_pop),
      .o_head  (w_head[c*WIDTH +: WIDTH]),
      .o_full  (bus.o_full[c]),
      .o_empty (w_empty[c]),
      .o_stop  (bus.o_stop[c]),
      .o_error (bus.o_error[c])
    );

`ifdef LI_INPUT_BUFFER_BYPASS_EN
    assign w_ready[c]                = !w_empty[c] || bus.i_enq[c];
    assign w_data[c*WIDTH +: WIDTH]  = w_empty[c] ? bus.i_data[c*WIDTH +: WIDTH]
                                                  : w_head[c*WIDTH +: WIDTH];
`else
    assign w_ready[c]                = !w_empty[c];
    assign w_data[c*WIDTH +: WIDTH]  = w_head[c*WIDTH +: WIDTH];
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_li_multi_input_buffer.sv
// ============================================================================
//  Module     : tb_li_multi_input_buffer
//  Description: Randomized and directed bench with a queue-based reference model.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_li_multi_input_buffer;

  localparam int WIDTH = 6;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];
  logic [1:0]       exp_err = 2'b00;

  li_multi_input_buffer_if #(.WIDTH(WIDTH), .CHANNELS(2)) bus ();

  li_multi_input_buffer #(
    .WIDTH(WIDTH), .ADDR(2), .CHANNELS(2), .AF_MARGIN(1)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor + reference model: queues hold what each channel should present.
  always @(negedge clk) begin
    if (!rst) begin
      int               sz [2];
      logic [1:0]       rdy, e_empty, e_full, e_stop, acc;
      logic             e_valid, pop;
      logic [WIDTH-1:0] head [2];
      logic [WIDTH-1:0] din  [2];
      sz[0] = q0.size();
      sz[1] = q1.size();
      din[0] = bus.i_data[0 +: WIDTH];
      din[1] = bus.i_data[WIDTH +: WIDTH];
      for (int c = 0; c < 2; c++) begin
        rdy[c]     = (sz[c] > 0);
`ifdef LI_INPUT_BUFFER_BYPASS_EN
        rdy[c]     = rdy[c] || bus.i_enq[c];
`endif
        e_empty[c] = (sz[c] == 0);
        e_full[c]  = (sz[c] == DEPTH);
        e_stop[c]  = (sz[c] >= DEPTH - 1);
      end
      head[0] = (sz[0] > 0) ? q0[0] : din[0];
      head[1] = (sz[1] > 0) ? q1[0] : din[1];
      e_valid = &rdy;
      chk("valid", 32'(bus.o_valid), 32'(e_valid));
      chk("empty", 32'(bus.o_empty), 32'(e_empty));
      chk("full",  32'(bus.o_full),  32'(e_full));
      chk("stop",  32'(bus.o_stop),  32'(e_stop));
      chk("error", 32'(bus.o_error), 32'(exp_err));
      if (e_valid) begin
        chk("data0", 32'(bus.o_data[0 +: WIDTH]), 32'(head[0]));
        chk("data1", 32'(bus.o_data[WIDTH +: WIDTH]), 32'(head[1]));
      end
      pop = bus.i_deq && e_valid;
      for (int c = 0; c < 2; c++) begin
        acc[c] = bus.i_enq[c] && (sz[c] < DEPTH || pop) && !(pop && sz[c] == 0);
        if (bus.i_enq[c] && sz[c] == DEPTH && !pop) exp_err[c] = 1'b1;
      end
      if (pop && sz[0] > 0) void'(q0.pop_front());
      if (pop && sz[1] > 0) void'(q1.pop_front());
      if (acc[0]) q0.push_back(din[0]);
      if (acc[1]) q1.push_back(din[1]);
    end
  end

  task automatic drive(input logic [1:0] enq, input logic [WIDTH-1:0] d0,
                       input logic [WIDTH-1:0] d1, input logic deq);
    bus.i_enq  = enq;
    bus.i_data = {d1, d0};
    bus.i_deq  = deq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_enq  = '0;
    bus.i_data = '0;
    bus.i_deq  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_data", 32'(bus.o_data), 32'h0);
    repeat (5) drive(2'b00, 0, 0, 1'b0);

    // Single aligned token then dequeue.
    drive(2'b11, 6'h05, 6'h2A, 1'b0);
    drive(2'b00, 0, 0, 1'b1);
    drive(2'b00, 0, 0, 1'b0);

    // Fill channel 0 alone, overflow, then enqueue+pop while full.
    repeat (3) drive(2'b01, 6'h01, 0, 1'b0);
    drive(2'b10, 0, 6'h07, 1'b0);
    drive(2'b01, 6'h04, 0, 1'b0);
    drive(2'b01, 6'h05, 0, 1'b0);
    drive(2'b11, 6'h06, 6'h08, 1'b1);
    repeat (6) drive(2'b00, 0, 0, 1'b1);

    // Streaming with pointer wrap.
    for (int i = 0; i < 10; i++) drive(2'b11, WIDTH'(i), WIDTH'(i), 1'b1);
    repeat (3) drive(2'b00, 0, 0, 1'b1);

    // Randomized: balanced, then heavy enqueue, then drain.
    for (int i = 0; i < 200; i++)
      drive({$urandom_range(99) < 70, $urandom_range(99) < 70},
            WIDTH'($urandom), WIDTH'($urandom), $urandom_range(99) < 60);
    for (int i = 0; i < 40; i++)
      drive({$urandom_range(99) < 90, $urandom_range(99) < 90},
            WIDTH'($urandom), WIDTH'($urandom), $urandom_range(99) < 10);
    for (int i = 0; i < 10; i++) drive(2'b00, 0, 0, 1'b1);

    // Asynchronous reset between edges with words queued.
    repeat (3) drive(2'b11, 6'h15, 6'h26, 1'b0);
    #3;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    exp_err = 2'b00;
    #1;
    chk("arst_empty", 32'(bus.o_empty), 32'h3);
    chk("arst_valid", 32'(bus.o_valid), 32'h0);
    chk("arst_full",  32'(bus.o_full),  32'h0);
    chk("arst_stop",  32'(bus.o_stop),  32'h0);
    chk("arst_error", 32'(bus.o_error), 32'h0);
    chk("arst_data",  32'(bus.o_data),  32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) drive(2'b00, 0, 0, 1'b0);
    drive(2'b11, 6'h11, 6'h22, 1'b1);
    repeat (3) drive(2'b00, 0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
